ahb_resp_mux_n: RTL and testbench

AHB_RESP_MUX_N -- requirements
Module: ahb_resp_mux_n

---
 rtl/ahb_resp_mux_n.sv | 128 ++++++++++++
 tb/tb_ahb_resp_mux_n.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite response multiplexer for N subordinates: forwards the selected
// subordinate's data phase, answers bad decodes itself and aborts stalled transfers.
module ahb_resp_mux_n #(
    parameter int DATA_WIDTH         = 32,
    parameter int NO_OF_SUBORDINATES = 4,
    parameter int TIMEOUT            = 16
) (
    input  logic                                     HCLK,
    input  logic                                     HRESETn,
    input  logic [NO_OF_SUBORDINATES-1:0]            HSEL,
    input  logic [1:0]                               HTRANS,
    input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [2*NO_OF_SUBORDINATES-1:0]          HRESP_S,
    input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
    input  logic                                     CLR_STATUS,
    output logic [DATA_WIDTH-1:0]                    HRDATA,
    output logic [1:0]                               HRESP,
    output logic                                     HREADY,
    output logic [7:0]                               ERR_CNT,
    output logic                                     TIMEOUT_FLAG
);

    // state | meaning
    // IDLE  | no data phase in progress, mux answers OKAY
    // SUB   | data phase owned by the subordinate in sel_q
    // ERR1  | first (wait) cycle of a mux-generated ERROR
    // ERR2  | second (ready) cycle of a mux-generated ERROR
    typedef enum logic [1:0] {IDLE, SUB, ERR1, ERR2} state_t;

    localparam int N  = NO_OF_SUBORDINATES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          state, state_nxt;
    logic [N-1:0]    sel_q;
    logic            act_q;
    logic [CW-1:0]   wd_cnt, wd_cnt_nxt;
    logic [IW-1:0]   sel_idx;
    logic            sub_ready;
    logic [1:0]      sub_resp;
    logic [DATA_WIDTH-1:0] sub_data;
    logic            wd_fire;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q[i]) sel_idx = IW'(i);
        end
    end

    assign sub_ready = HREADYOUT_S[sel_idx];
    assign sub_resp  = HRESP_S[2*sel_idx +: 2];
    assign sub_data  = HRDATA_S[sel_idx*DATA_WIDTH +: DATA_WIDTH];

    // Fires on the last wait cycle; a ready on that same cycle wins.
    assign wd_fire = (TIMEOUT > 0) && (state == SUB) && !sub_ready && (wd_cnt == WD_LAST);

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        case (state)
            SUB: begin
                if (act_q) begin
                    HREADY = sub_ready;
                    HRESP  = sub_resp;
                    HRDATA = sub_data;
                end
            end
            ERR1: begin
                HREADY = 1'b0;
                HRESP  = 2'b01;
            end
            ERR2:    HRESP = 2'b01;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        wd_cnt_nxt = wd_cnt;
        case (state)
            ERR1: state_nxt = ERR2;
            SUB: begin
                if (wd_fire)
                    state_nxt = ERR1;
                else if (!sub_ready && TIMEOUT > 0)
                    wd_cnt_nxt = CW'(wd_cnt + 1'b1);
            end
            default: ;
        endcase
        if (HREADY) begin
            wd_cnt_nxt = '0;
            if (HTRANS[1])
                state_nxt = $onehot(HSEL) ? SUB : ERR1;
            else
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            sel_q        <= '0;
            act_q        <= 1'b0;
            wd_cnt       <= '0;
            ERR_CNT      <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            state  <= state_nxt;
            wd_cnt <= wd_cnt_nxt;
            if (HREADY) begin
                sel_q <= HSEL;
                act_q <= HTRANS[1];
            end
            if (CLR_STATUS)
                ERR_CNT <= '0;
            else if (state_nxt == ERR1 && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;
            if (CLR_STATUS)
                TIMEOUT_FLAG <= 1'b0;
            else if (wd_fire)
                TIMEOUT_FLAG <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n (4 subordinates, 32-bit data, TIMEOUT=16).
module tb_ahb_resp_mux_n;

    logic         HCLK;
    logic         HRESETn;
    logic [3:0]   HSEL;
    logic [1:0]   HTRANS;
    logic [127:0] HRDATA_S;
    logic [7:0]   HRESP_S;
    logic [3:0]   HREADYOUT_S;
    logic         CLR_STATUS;
    logic [31:0]  HRDATA;
    logic [1:0]   HRESP;
    logic         HREADY;
    logic [7:0]   ERR_CNT;
    logic         TIMEOUT_FLAG;

    int total = 0;
    int bad   = 0;

    ahb_resp_mux_n #(.DATA_WIDTH(32), .NO_OF_SUBORDINATES(4), .TIMEOUT(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S), .HREADYOUT_S(HREADYOUT_S),
        .CLR_STATUS(CLR_STATUS), .HRDATA(HRDATA), .HRESP(HRESP), .HREADY(HREADY),
        .ERR_CNT(ERR_CNT), .TIMEOUT_FLAG(TIMEOUT_FLAG)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic addr(input logic [3:0] sel, input logic [1:0] trans);
        HSEL   = sel;
        HTRANS = trans;
    endtask

    initial begin
        int  low;
        bit  done;
        HRESETn     = 1'b0;
        HSEL        = '0;
        HTRANS      = 2'b00;
        HRDATA_S    = {32'h4444_0003, 32'hA5A5_0001, 32'h2222_0001, 32'h1111_0000};
        HRESP_S     = '0;
        HREADYOUT_S = 4'hF;
        CLR_STATUS  = 1'b0;
        #12;
        chk("rst_hready", HREADY, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_errcnt", ERR_CNT, 0);
        chk("rst_flag", TIMEOUT_FLAG, 0);
        step();
        HRESETn = 1'b1;

        // normal read from subordinate 2
        step(); addr(4'b0100, 2'b10);
        step(); addr(4'b0000, 2'b00); #1;
        chk("sub2_data", HRDATA, 32'hA5A5_0001);
        chk("sub2_resp", HRESP, 0);
        chk("sub2_ready", HREADY, 1);
        step(); #1;
        chk("idle_data", HRDATA, 0);

        // decode error, no subordinate selected
        addr(4'b0000, 2'b10);
        step(); addr(4'b0000, 2'b00); #1;
        chk("dec0_err1_ready", HREADY, 0);
        chk("dec0_err1_resp", HRESP, 1);
        chk("dec0_cnt", ERR_CNT, 1);
        step(); #1;
        chk("dec0_err2_ready", HREADY, 1);
        chk("dec0_err2_resp", HRESP, 1);
        step(); #1;
        chk("dec0_idle_resp", HRESP, 0);
        chk("dec0_flag", TIMEOUT_FLAG, 0);

        // multi-hot decode error
        addr(4'b0011, 2'b10);
        step(); addr(4'b0000, 2'b00); #1;
        chk("multi_err1_ready", HREADY, 0);
        chk("multi_err1_resp", HRESP, 1);
        step(); #1;
        chk("multi_err2_resp", HRESP, 1);
        chk("multi_cnt", ERR_CNT, 2);
        step(); #1;
        chk("idle_ready", HREADY, 1);
        chk("idle_resp", HRESP, 0);
        step(); #1;
        chk("idle_nocount", ERR_CNT, 2);

        // subordinate ERROR passes through uncounted
        HRESP_S = 8'b0000_0001;
        addr(4'b0001, 2'b10);
        step(); addr(4'b0000, 2'b00); #1;
        chk("suberr_resp", HRESP, 1);
        chk("suberr_data", HRDATA, 32'h1111_0000);
        step(); #1;
        chk("suberr_nocount", ERR_CNT, 2);
        HRESP_S = '0;

        // watchdog on subordinate 1
        HREADYOUT_S = 4'b1101;
        addr(4'b0010, 2'b10);
        step(); addr(4'b0000, 2'b00);
        low = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (HRESP == 2'b01) done = 1;
            else begin
                if (!HREADY) low++;
                step();
            end
        end
        chk("wd_reached_err", done, 1);
        chk("wd_low_cycles", low, 16);
        chk("wd_err1_ready", HREADY, 0);
        chk("wd_flag", TIMEOUT_FLAG, 1);
        chk("wd_cnt", ERR_CNT, 3);
        HREADYOUT_S = 4'hF;
        step(); #1;
        chk("wd_err2_ready", HREADY, 1);
        chk("wd_err2_resp", HRESP, 1);
        step(); #1;
        chk("wd_idle_resp", HRESP, 0);

        // clear status
        CLR_STATUS = 1'b1;
        step(); CLR_STATUS = 1'b0; #1;
        chk("clr_cnt", ERR_CNT, 0);
        chk("clr_flag", TIMEOUT_FLAG, 0);

        // ready on the 16th cycle completes normally
        HREADYOUT_S = 4'b1101;
        addr(4'b0010, 2'b10);
        step(); addr(4'b0000, 2'b00);
        for (int i = 0; i < 14; i++) step();
        #1;
        chk("late_15th_ready", HREADY, 0);
        step(); HREADYOUT_S = 4'hF; #1;
        chk("late_ready", HREADY, 1);
        chk("late_resp", HRESP, 0);
        chk("late_data", HRDATA, 32'h2222_0001);
        step(); #1;
        chk("late_flag", TIMEOUT_FLAG, 0);
        chk("late_cnt", ERR_CNT, 0);

        // back-to-back decode errors up to saturation
        addr(4'b0000, 2'b10);
        for (int i = 0; i < 507; i++) step();
        #1;
        chk("sat_254", ERR_CNT, 254);
        for (int i = 0; i < 5; i++) step();
        #1;
        chk("sat_255", ERR_CNT, 255);
        chk("sat_err2_ready", HREADY, 1);
        CLR_STATUS = 1'b1;
        step(); CLR_STATUS = 1'b0; addr(4'b0000, 2'b00); #1;
        chk("clr_prio_cnt", ERR_CNT, 0);
        chk("clr_prio_resp", HRESP, 1);
        step(); step(); #1;
        chk("clr_prio_idle", HRESP, 0);

        // reset during a subordinate wait
        HREADYOUT_S = 4'b1011;
        addr(4'b0100, 2'b10);
        step(); addr(4'b0000, 2'b00);
        step(); step(); #1;
        chk("rstmid_waiting", HREADY, 0);
        #2 HRESETn = 1'b0; #1;
        chk("rstmid_ready", HREADY, 1);
        chk("rstmid_resp", HRESP, 0);
        chk("rstmid_data", HRDATA, 0);
        chk("rstmid_cnt", ERR_CNT, 0);
        step(); HRESETn = 1'b1;
        step(); #1;
        chk("rstmid_after", HREADY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
